// File: rtl/button_deb_pkg.sv
// Shared constants and helpers for the multi-channel button debouncer.
// Holds default timing values and the width helpers used to size counters.
package button_deb_pkg;

    localparam int DEF_CLK_FREQ        = 95_000;
    localparam int DEF_DEBOUNCE_PER_MS = 20;
    localparam int DEF_LONG_PRESS_MS   = 1000;
    localparam int DEF_NB_BUTTONS      = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a counter that must be able to hold max_count itself, never below one bit.
    function automatic int cnt_width(input int max_count);
        int w;
        w = clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of a counter running 0..modulus-1, never below one bit.
    function automatic int mod_width(input int modulus);
        int w;
        w = clog2(modulus);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DEF_PRESCALE_W = mod_width(DEF_CLK_FREQ);
    localparam int DEF_DEBOUNCE_W = cnt_width(DEF_DEBOUNCE_PER_MS);
    localparam int DEF_HOLD_W     = cnt_width(DEF_LONG_PRESS_MS);

endpackage

// File: rtl/button_deb_chan.sv
// One debouncer channel: 2-flop synchroniser, ms-based debounce counter and edge pulses.
// The long-press hold counter exists only when BUTTON_DEB_LONG_PRESS_EN is defined.
module button_deb_chan
    import button_deb_pkg::*;
#(
    parameter int DEBOUNCE_PER_MS = DEF_DEBOUNCE_PER_MS,
    parameter int LONG_PRESS_MS   = DEF_LONG_PRESS_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic ms_tick,
    input  logic button_in,
    output logic button_valid,
    output logic button_rise,
    output logic button_fall,
    output logic button_long
);

    localparam int DEB_W = cnt_width(DEBOUNCE_PER_MS);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_PER_MS - 1);

    logic             sync1;
    logic             sync;
    logic [DEB_W-1:0] deb_cnt;
    logic             accept;

    if (DEBOUNCE_PER_MS < 1) begin : g_bad_debounce
        $error("button_deb_chan: DEBOUNCE_PER_MS must be >= 1");
    end
    if (LONG_PRESS_MS <= DEBOUNCE_PER_MS) begin : g_bad_long_press
        $error("button_deb_chan: LONG_PRESS_MS must exceed DEBOUNCE_PER_MS");
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync  <= 1'b0;
        end else begin
            sync1 <= button_in;
            sync  <= sync1;
        end
    end

    // The tick that brings the count to DEBOUNCE_PER_MS is the one that accepts the new level.
    assign accept = (sync != button_valid) && ms_tick && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt      <= '0;
            button_valid <= 1'b0;
        end else if (sync == button_valid) begin
            deb_cnt <= '0;
        end else if (accept) begin
            deb_cnt      <= '0;
            button_valid <= sync;
        end else if (ms_tick) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            button_rise <= 1'b0;
            button_fall <= 1'b0;
        end else begin
            button_rise <= accept && sync;
            button_fall <= accept && !sync;
        end
    end

`ifdef BUTTON_DEB_LONG_PRESS_EN
    localparam int HOLD_W = cnt_width(LONG_PRESS_MS);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_MS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_MS - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Saturation at HOLD_MAX is what limits the long pulse to once per accepted press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt    <= '0;
            button_long <= 1'b0;
        end else begin
            button_long <= 1'b0;
            if (!button_valid) begin
                hold_cnt <= '0;
            end else if (ms_tick && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
                if (hold_cnt == HOLD_LAST) begin
                    button_long <= 1'b1;
                end
            end
        end
    end
`else
    assign button_long = 1'b0;
`endif

endmodule

// File: rtl/button_deb_multi.sv
// Multi-channel button debouncer: one shared 1 ms prescaler feeding NB_BUTTONS channels.
// Long-press detection is enabled by defining BUTTON_DEB_LONG_PRESS_EN.
module button_deb_multi
    import button_deb_pkg::*;
#(
    parameter int CLK_FREQ        = DEF_CLK_FREQ,
    parameter int DEBOUNCE_PER_MS = DEF_DEBOUNCE_PER_MS,
    parameter int NB_BUTTONS      = DEF_NB_BUTTONS,
    parameter int LONG_PRESS_MS   = DEF_LONG_PRESS_MS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NB_BUTTONS-1:0] button_in,
    output logic [NB_BUTTONS-1:0] button_valid,
    output logic [NB_BUTTONS-1:0] button_rise,
    output logic [NB_BUTTONS-1:0] button_fall,
    output logic [NB_BUTTONS-1:0] button_long
);

    localparam int PRE_W = mod_width(CLK_FREQ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             ms_tick;

    if (CLK_FREQ < 2) begin : g_bad_clk_freq
        $error("button_deb_multi: CLK_FREQ must be >= 2");
    end
    if (NB_BUTTONS < 1) begin : g_bad_nb_buttons
        $error("button_deb_multi: NB_BUTTONS must be >= 1");
    end

    assign ms_tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (ms_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    for (genvar ch = 0; ch < NB_BUTTONS; ch++) begin : g_chan
        button_deb_chan #(
            .DEBOUNCE_PER_MS (DEBOUNCE_PER_MS),
            .LONG_PRESS_MS   (LONG_PRESS_MS)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .ms_tick      (ms_tick),
            .button_in    (button_in[ch]),
            .button_valid (button_valid[ch]),
            .button_rise  (button_rise[ch]),
            .button_fall  (button_fall[ch]),
            .button_long  (button_long[ch])
        );
    end

endmodule
